// File: rtl/writeback_stage.sv
// MIPS MEM/WB stage: selects ALU or extended load data and drives the register-file write port.
// Optional WB_FORWARD_EN adds same-cycle read-after-write bypass compares against the write port.
module writeback_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic             in_memtoreg,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_aluresult,
  input  logic [31:0]      in_memdata,
  input  logic [1:0]       in_loadsize,
  input  logic             in_loadunsigned,
`ifdef WB_FORWARD_EN
  input  logic [4:0]       fwd_rs,
  input  logic [4:0]       fwd_rt,
  output logic             fwd_a_hit,
  output logic             fwd_b_hit,
`endif
  output logic             wb_valid,
  output logic [4:0]       rd,
  output logic [31:0]      writedata,
  output logic             regwrite,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  logic [1:0]       addrlo;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;
  logic             mis_raw;
  logic [31:0]      writedata_d;
  logic             regwrite_d;

  logic             valid_q;
  logic [4:0]       rd_q;
  logic [31:0]      writedata_q;
  logic             regwrite_q;
  logic             misalign_q;
  logic [CNT_W-1:0] retired_q;

  assign addrlo = in_aluresult[1:0];

  // Big-endian lanes: the lowest address owns the most significant byte.
  always_comb begin
    byte_sel = in_memdata[31:24];
    unique case (addrlo)
      2'd0: byte_sel = in_memdata[31:24];
      2'd1: byte_sel = in_memdata[23:16];
      2'd2: byte_sel = in_memdata[15:8];
      2'd3: byte_sel = in_memdata[7:0];
      default: byte_sel = in_memdata[31:24];
    endcase
    half_sel = addrlo[1] ? in_memdata[15:0] : in_memdata[31:16];
  end

  always_comb begin
    load_ext = in_memdata;
    case (in_loadsize)
      SizeByte: load_ext = in_loadunsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SizeHalf: load_ext = in_loadunsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  load_ext = in_memdata;
    endcase
  end

  always_comb begin
    mis_raw = 1'b0;
    if (in_memtoreg) begin
      if (in_loadsize == SizeHalf) begin
        mis_raw = addrlo[0];
      end else if (in_loadsize == SizeWord || in_loadsize == SizeRsvd) begin
        mis_raw = (addrlo != 2'd0);
      end
    end
    if (!in_memtoreg) begin
      writedata_d = in_aluresult;
    end else if (mis_raw) begin
      writedata_d = in_memdata;
    end else begin
      writedata_d = load_ext;
    end
    regwrite_d = in_valid & in_regwrite & (in_rd != 5'd0) & ~mis_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rd_q        <= 5'd0;
      writedata_q <= 32'd0;
      regwrite_q  <= 1'b0;
      misalign_q  <= 1'b0;
      retired_q   <= '0;
    end else if (flush) begin
      // Bubble: rd and writedata keep their last values.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= in_valid;
      rd_q        <= in_rd;
      writedata_q <= writedata_d;
      regwrite_q  <= regwrite_d;
      misalign_q  <= in_valid & mis_raw;
      if (in_valid) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign wb_valid  = valid_q;
  assign rd        = rd_q;
  assign writedata = writedata_q;
  assign regwrite  = regwrite_q;
  assign misalign  = misalign_q;
  assign retired   = retired_q;

`ifdef WB_FORWARD_EN
  assign fwd_a_hit = regwrite_q & (rd_q == fwd_rs);
  assign fwd_b_hit = regwrite_q & (rd_q == fwd_rt);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: arithmetic reference model checked every cycle
// plus hand-computed expectations for the listed scenarios.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        in_valid, in_regwrite, in_memtoreg, in_loadunsigned;
  logic [4:0]  in_rd;
  logic [31:0] in_aluresult, in_memdata;
  logic [1:0]  in_loadsize;
  logic [4:0]  fwd_rs, fwd_rt;

  logic        wb_valid, regwrite, misalign;
  logic [4:0]  rd;
  logic [31:0] writedata, retired;
  logic        wb_valid4, regwrite4, misalign4;
  logic [4:0]  rd4;
  logic [31:0] writedata4;
  logic [3:0]  retired4;
  logic        fwd_a_hit, fwd_b_hit, fwd_a_hit4, fwd_b_hit4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  writeback_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_rd(in_rd), .in_aluresult(in_aluresult), .in_memdata(in_memdata),
    .in_loadsize(in_loadsize), .in_loadunsigned(in_loadunsigned),
`ifdef WB_FORWARD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
`endif
    .wb_valid(wb_valid), .rd(rd), .writedata(writedata), .regwrite(regwrite),
    .misalign(misalign), .retired(retired)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_rd(in_rd), .in_aluresult(in_aluresult), .in_memdata(in_memdata),
    .in_loadsize(in_loadsize), .in_loadunsigned(in_loadunsigned),
`ifdef WB_FORWARD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_a_hit(fwd_a_hit4), .fwd_b_hit(fwd_b_hit4),
`endif
    .wb_valid(wb_valid4), .rd(rd4), .writedata(writedata4), .regwrite(regwrite4),
    .misalign(misalign4), .retired(retired4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_mis(input logic m2r, input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (!m2r) return 1'b0;
    if (size == 2'd1) return (a % 2) == 1;
    if (size == 2'd2) return 1'b0;
    return a != 0;
  endfunction

  function automatic logic [31:0] model_wd(input logic m2r, input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] mem,
                                           input logic [31:0] alu);
    logic [31:0] v;
    int a = int'(addr % 4);
    if (!m2r) return alu;
    if (model_mis(m2r, size, addr)) return mem;
    if (size == 2'd2) begin
      v = (mem >> (8 * (3 - a))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (mem >> (16 * (1 - a / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  logic        e_valid, e_rw, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  int unsigned e_ret, e_ret4;

  always @(posedge clk) begin
    if (!rst_n) begin
      e_valid <= 0; e_rw <= 0; e_mis <= 0; e_rd <= 0; e_wd <= 0; e_ret <= 0; e_ret4 <= 0;
    end else if (flush) begin
      e_valid <= 0; e_rw <= 0; e_mis <= 0;
    end else if (!stall) begin
      e_valid <= in_valid;
      e_rd    <= in_rd;
      e_wd    <= model_wd(in_memtoreg, in_loadsize, in_loadunsigned, in_aluresult, in_memdata,
                          in_aluresult);
      e_mis   <= in_valid && model_mis(in_memtoreg, in_loadsize, in_aluresult);
      e_rw    <= in_valid && in_regwrite && in_rd != 0 &&
                 !model_mis(in_memtoreg, in_loadsize, in_aluresult);
      if (in_valid) begin
        e_ret  <= e_ret + 1;
        e_ret4 <= (e_ret4 + 1) % 16;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_valid", {31'd0, wb_valid}, {31'd0, e_valid});
      check("rd", {27'd0, rd}, {27'd0, e_rd});
      check("writedata", writedata, e_wd);
      check("regwrite", {31'd0, regwrite}, {31'd0, e_rw});
      check("misalign", {31'd0, misalign}, {31'd0, e_mis});
      check("retired", retired, e_ret);
      check("retired4", {28'd0, retired4}, e_ret4);
      check("writedata4", writedata4, e_wd);
`ifdef WB_FORWARD_EN
      check("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, e_rw && e_rd == fwd_rs});
      check("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, e_rw && e_rd == fwd_rt});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] size,
                       input logic uns);
    in_valid = v; in_regwrite = rw; in_memtoreg = m2r; in_rd = d;
    in_aluresult = alu; in_memdata = mem; in_loadsize = size; in_loadunsigned = uns;
    cyc();
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; fwd_rs = 0; fwd_rt = 0;
    in_valid = 1; in_regwrite = 1; in_memtoreg = 0; in_rd = 5'd3;
    in_aluresult = 32'h55; in_memdata = 0; in_loadsize = 0; in_loadunsigned = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_valid", {31'd0, wb_valid}, 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_wd", writedata, 32'd0);
    rst_n = 1;

    drive(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 2'd0, 0);
    check("alu_rd", {27'd0, rd}, 32'd5);
    check("alu_wd", writedata, 32'h0000_1234);
    check("alu_rw", {31'd0, regwrite}, 32'd1);
    check("alu_ret", retired, 32'd1);

    drive(1, 1, 1, 5'd3, 32'h1000, 32'h80FF_7F01, 2'b10, 0);
    check("lb_0", writedata, 32'hFFFF_FF80);
    drive(1, 1, 1, 5'd3, 32'h1001, 32'h80FF_7F01, 2'b10, 1);
    check("lbu_1", writedata, 32'h0000_00FF);
    drive(1, 1, 1, 5'd3, 32'h1002, 32'h80FF_7F01, 2'b10, 0);
    check("lb_2", writedata, 32'h0000_007F);
    drive(1, 1, 1, 5'd3, 32'h1003, 32'h80FF_7F01, 2'b10, 0);
    check("lb_3", writedata, 32'h0000_0001);

    drive(1, 1, 1, 5'd4, 32'h2001, 32'h1234_8000, 2'b01, 0);
    check("lh_mis", {31'd0, misalign}, 32'd1);
    check("lh_mis_rw", {31'd0, regwrite}, 32'd0);
    check("lh_mis_wd", writedata, 32'h1234_8000);
    check("lh_mis_ret", retired, 32'd6);
    drive(1, 1, 1, 5'd4, 32'h2002, 32'h1234_8000, 2'b01, 0);
    check("lh_2", writedata, 32'hFFFF_8000);
    check("lh_2_mis", {31'd0, misalign}, 32'd0);
    drive(1, 1, 1, 5'd4, 32'h2000, 32'h1234_8000, 2'b01, 1);
    check("lhu_0", writedata, 32'h0000_1234);
    drive(1, 1, 1, 5'd4, 32'h2002, 32'h1234_8000, 2'b00, 0);
    check("lw_mis", {31'd0, misalign}, 32'd1);
    drive(1, 1, 1, 5'd4, 32'h2004, 32'h1234_8000, 2'b11, 0);
    check("lw_rsvd", writedata, 32'h1234_8000);
    check("lw_rsvd_rw", {31'd0, regwrite}, 32'd1);
    drive(1, 1, 0, 5'd6, 32'h0000_0003, 32'h0, 2'b00, 0);
    check("alu_odd_mis", {31'd0, misalign}, 32'd0);

    drive(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'd0, 0);
    check("rd0_rw", {31'd0, regwrite}, 32'd0);
    check("rd0_valid", {31'd0, wb_valid}, 32'd1);
    drive(0, 1, 0, 5'd8, 32'h88, 32'h0, 2'd0, 0);
    check("inv_valid", {31'd0, wb_valid}, 32'd0);
    check("inv_rw", {31'd0, regwrite}, 32'd0);
    check("inv_ret", retired, 32'd12);

    drive(1, 1, 0, 5'd7, 32'h77, 32'h0, 2'd0, 0);
    stall = 1;
    drive(1, 1, 0, 5'd10, 32'hAA, 32'h0, 2'd0, 0);
    drive(1, 1, 1, 5'd11, 32'h2001, 32'h1, 2'b01, 0);
    drive(0, 0, 0, 5'd12, 32'hCC, 32'h0, 2'd0, 0);
    check("stall_rd", {27'd0, rd}, 32'd7);
    check("stall_wd", writedata, 32'h77);
    check("stall_rw", {31'd0, regwrite}, 32'd1);
    check("stall_ret", retired, 32'd13);
    flush = 1;
    drive(1, 1, 0, 5'd13, 32'hDD, 32'h0, 2'd0, 0);
    check("flush_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_rw", {31'd0, regwrite}, 32'd0);
    check("flush_rd", {27'd0, rd}, 32'd7);
    check("flush_ret", retired, 32'd13);
    flush = 0; stall = 0;

    drive(1, 1, 0, 5'd14, 32'hEE, 32'h0, 2'd0, 0);
    rst_n = 0;
    drive(1, 1, 0, 5'd15, 32'hFF, 32'h0, 2'd0, 0);
    check("midrst_ret", retired, 32'd0);
    check("midrst_valid", {31'd0, wb_valid}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 5'(i + 1), 32'(i), 32'h0, 2'd0, 0);
    end
    check("wrap_ret4", {28'd0, retired4}, 32'd1);
    check("wrap_ret32", retired, 32'd17);

    fwd_rs = 5'd9; fwd_rt = 5'd8;
    drive(1, 1, 0, 5'd9, 32'h99, 32'h0, 2'd0, 0);
`ifdef WB_FORWARD_EN
    check("fwd_a", {31'd0, fwd_a_hit}, 32'd1);
    check("fwd_b", {31'd0, fwd_b_hit}, 32'd0);
    fwd_rt = 5'd9;
    #1;
    check("fwd_b_now", {31'd0, fwd_b_hit}, 32'd1);
    flush = 1;
    cyc();
    check("fwd_a_flush", {31'd0, fwd_a_hit}, 32'd0);
    flush = 0;
`endif
    cyc();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
